pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Output-side complement to the key-press edge detector: it takes single-cycle event pulses and turns each one into a fixed-length, human-visible level on a board output such as an LED or buzzer. Events that arrive while an output pulse is playing are queued in a saturating pending counter and replayed in order, separated by a guaranteed low gap. It sits between a one-cycle event source and a GPIO or LEDR pin.

## Interface
- ON_CYCLES, 4, length of each output high period in clk cycles (≥1)
- GAP_CYCLES, 2, minimum low period between consecutive output pulses (≥0)
- MAX_PENDING, 3, depth of the pending-event queue (≥1)
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pulse  in  1  event input, synchronous to clk; each high cycle is one event
- out  out  1  stretched output level, registered
- busy  out  1  high while an output pulse or gap is in progress, registered
- pending  out  $clog2(MAX_PENDING+1)  number of queued events not yet played
- ovf  out  1  sticky high once any event has been dropped (see Configuration)

## Operation
- States: IDLE, ON, GAP. Cycle counter cnt, width $clog2(max(ON_CYCLES,GAP_CYCLES)+1).
- IDLE: pulse=1 → ON, cnt=1. pulse=0 → stay.
- ON: cnt==ON_CYCLES → GAP with cnt=1, or directly to the "after gap" decision when GAP_CYCLES==0. Otherwise cnt+1.
- GAP: cnt==GAP_CYCLES → after-gap decision. Otherwise cnt+1.
- After-gap decision: pending>0 → ON, cnt=1, pending−1. Otherwise IDLE.
- Queueing: pulse=1 in any cycle where the FSM does not leave IDLE on that edge → pending+1 if pending<MAX_PENDING. If pending==MAX_PENDING, the event is dropped.
- Simultaneous enqueue and dequeue on the same edge: pending is unchanged and no event is lost.
- out = (state==ON). busy = (state!=IDLE). Both come straight from registers; there are no combinational paths from pulse to any output.
- A pulse held high for N cycles counts as N events. Upstream logic is responsible for guaranteeing single-cycle events.
- Reset, including mid-operation: state=IDLE, cnt=0, pending=0, out=0, busy=0, ovf=0, all asynchronously. The first clk edge after reset is released samples pulse normally.

## Timing
- Latency: pulse sampled high at edge k from IDLE → out high for cycles following edges k..k+ON_CYCLES−1, then low.
- Minimum spacing between rising edges of out: ON_CYCLES+GAP_CYCLES cycles.
- When GAP_CYCLES==0, queued pulses merge into one continuous high level. This is accepted behaviour.
- pending and ovf update on the same edge as the event that causes the change.

## Configuration
- PULSE_STRETCH_OVF_EN defined: ovf is set on the first dropped event and held until reset.
- PULSE_STRETCH_OVF_EN undefined: the ovf port remains but is tied to 0, no overflow register is built, and dropped events are silently discarded.

## Structure
- Shared package pulse_stretcher_pkg: typedef enum logic [1:0] {IDLE, ON, GAP} ps_state_t.
- Widths stay local, because they are derived from module parameters.
- Sub-module sat_counter: a parameterised up/down counter with saturation at MAX and an overflow strobe. It holds the pending count.

## Test plan
All cases use ON=4, GAP=2, MAX_PENDING=3 unless noted; cycle n means the cycle following edge n.
- Single pulse at edge 2 → out=1 in cycles 2–5. busy=1 in cycles 2–7. pending stays 0. ovf=0.
- Pulses at edges 2, 3, 4 → out high in cycles 2–5, 8–11, 14–17. pending goes 1, 2, then 1 at edge 8 and 0 at edge 14.
- Pulses at edges 2–6 (five consecutive) → pending saturates at 3. The fifth event is dropped, with ovf=1 from edge 6 if the macro is defined, else 0. Exactly four out pulses are produced.
- Pending=1 and a pulse on the final GAP edge → next ON starts, pending stays 1, and one more pulse follows.
- Reset asserted mid-ON between clock edges → out, busy, pending and ovf all go to 0 before the next edge. After release, a single pulse repeats the first case.
- GAP_CYCLES=0, pulses at edges 2 and 3 → out high continuously in cycles 2–9. busy falls after cycle 9.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types for the pulse stretcher: the output FSM state encoding.
package pulse_stretcher_pkg;
    typedef enum logic [1:0] {IDLE, ON, GAP} ps_state_t;
endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up/down counter holding the pending-event count; o_ovf strobes
// when an increment is refused because the count is already at MAX.
module sat_counter #(
    parameter int MAX = 3,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_ovf
);
    logic [W-1:0] r_count;

    // Simultaneous inc and dec cancel, so a full counter never drops in that case.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_count != W'(MAX))
                r_count <= r_count + W'(1);
        end else if (i_dec && !i_inc && r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_ovf   = i_inc && !i_dec && (r_count == W'(MAX));
endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into ON_CYCLES-long output pulses separated by
// GAP_CYCLES low cycles; overflow flag is built only with PULSE_STRETCH_OVF_EN.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES   = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PENDING = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pulse,
    output logic                               out,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               ovf
);
    localparam int CMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(MAX_PENDING + 1);

    ps_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_out, r_busy;
    logic          w_enq, w_deq, w_drop;
    logic [PW-1:0] w_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= (w_state_nxt == ON);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // At the end of a gap an event arriving on that same edge starts the next
    // pulse directly, so nothing is ever parked in the queue while IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_deq       = 1'b0;
        case (r_state)
            IDLE: begin
                if (pulse) begin
                    w_state_nxt = ON;
                    w_cnt_nxt   = CW'(1);
                end
            end
            ON: begin
                if (r_cnt == CW'(ON_CYCLES)) begin
                    if (GAP_CYCLES == 0) begin
                        w_deq       = (w_pending != '0) || pulse;
                        w_state_nxt = w_deq ? ON : IDLE;
                        w_cnt_nxt   = w_deq ? CW'(1) : '0;
                    end else begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = CW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            GAP: begin
                if (r_cnt == CW'(GAP_CYCLES)) begin
                    w_deq       = (w_pending != '0) || pulse;
                    w_state_nxt = w_deq ? ON : IDLE;
                    w_cnt_nxt   = w_deq ? CW'(1) : '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_enq = pulse && (r_state != IDLE);

    sat_counter #(.MAX(MAX_PENDING), .W(PW)) u_pending (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_enq),
        .i_dec   (w_deq),
        .o_count (w_pending),
        .o_ovf   (w_drop)
    );

`ifdef PULSE_STRETCH_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
    end
    assign ovf = r_ovf;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
    assign ovf = 1'b0;
`endif

    assign out     = r_out;
    assign busy    = r_busy;
    assign pending = w_pending;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a schedule-based model (each accepted event
// gets a start edge) checked every cycle on a GAP=2 and a GAP=0 instance.
module tb_pulse_stretcher;
    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int MAXP = 3;
    localparam int PW   = $clog2(MAXP + 1);
`ifdef PULSE_STRETCH_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, pulse = 1'b0;
    logic out_a, busy_a, ovf_a, out_b, busy_b, ovf_b;
    logic [PW-1:0] pend_a, pend_b;

    always #5 clk = ~clk;

    pulse_stretcher #(.ON_CYCLES(ON), .GAP_CYCLES(GAP), .MAX_PENDING(MAXP)) dut_a (
        .clk(clk), .reset(reset), .pulse(pulse),
        .out(out_a), .busy(busy_a), .pending(pend_a), .ovf(ovf_a));

    pulse_stretcher #(.ON_CYCLES(ON), .GAP_CYCLES(0), .MAX_PENDING(MAXP)) dut_b (
        .clk(clk), .reset(reset), .pulse(pulse),
        .out(out_b), .busy(busy_b), .pending(pend_b), .ovf(ovf_b));

    int passed = 0, total = 0;
    int edge_n = 0;
    bit chk_en = 1'b0;

    // Model: list of start edges of every accepted event, per instance.
    int st[2][64];
    int nst[2];
    bit ovm[2];
    int h_out[2][64], h_busy[2][64], h_pend[2][64], h_ovf[2][64];

    function automatic int gapof(input int k);
        return (k == 0) ? GAP : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int m_pend(input int k, input int e);
        int n = 0;
        for (int i = 0; i < nst[k]; i++) if (st[k][i] > e) n++;
        return n;
    endfunction

    function automatic int m_out(input int k, input int e);
        for (int i = 0; i < nst[k]; i++)
            if (st[k][i] <= e && e < st[k][i] + ON) return 1;
        return 0;
    endfunction

    function automatic int m_busy(input int k, input int e);
        for (int i = 0; i < nst[k]; i++)
            if (st[k][i] <= e && e < st[k][i] + ON + gapof(k)) return 1;
        return 0;
    endfunction

    // An event starts immediately if the previous pulse+gap is finished,
    // otherwise it is scheduled one period after the last scheduled start.
    task automatic mdl_edge(input int k, input bit p);
        int last;
        if (!p) return;
        last = (nst[k] > 0) ? st[k][nst[k]-1] : -1000;
        if (edge_n >= last + ON + gapof(k)) begin
            st[k][nst[k]] = edge_n;
            nst[k]++;
        end else if (m_pend(k, edge_n) >= MAXP) begin
            ovm[k] = 1'b1;
        end else begin
            st[k][nst[k]] = last + ON + gapof(k);
            nst[k]++;
        end
    endtask

    always @(negedge clk) begin : cmp
        int e;
        if (chk_en) begin
            e = edge_n;
            chk($sformatf("out_a@%0d", e),  int'(out_a),  m_out(0, e));
            chk($sformatf("busy_a@%0d", e), int'(busy_a), m_busy(0, e));
            chk($sformatf("pend_a@%0d", e), int'(pend_a), m_pend(0, e));
            chk($sformatf("ovf_a@%0d", e),  int'(ovf_a),  int'(OVF_EN && ovm[0]));
            chk($sformatf("out_b@%0d", e),  int'(out_b),  m_out(1, e));
            chk($sformatf("busy_b@%0d", e), int'(busy_b), m_busy(1, e));
            chk($sformatf("pend_b@%0d", e), int'(pend_b), m_pend(1, e));
            chk($sformatf("ovf_b@%0d", e),  int'(ovf_b),  int'(OVF_EN && ovm[1]));
            if (e < 64) begin
                h_out[0][e] = int'(out_a); h_busy[0][e] = int'(busy_a);
                h_pend[0][e] = int'(pend_a); h_ovf[0][e] = int'(ovf_a);
                h_out[1][e] = int'(out_b); h_busy[1][e] = int'(busy_b);
                h_pend[1][e] = int'(pend_b); h_ovf[1][e] = int'(ovf_b);
            end
        end
    end

    task automatic restart();
        chk_en = 1'b0;
        reset  = 1'b1;
        nst[0] = 0; nst[1] = 0;
        ovm[0] = 1'b0; ovm[1] = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        edge_n = 0;
        chk_en = 1'b1;
    endtask

    task automatic scen(input logic [63:0] pat, input int len);
        for (int e = 1; e <= len; e++) begin
            pulse = pat[e];
            @(posedge clk);
            edge_n = e;
            mdl_edge(0, pulse);
            mdl_edge(1, pulse);
            #1;
        end
        pulse = 1'b0;
    endtask

    function automatic int rises(input int k, input int len);
        int n = 0;
        for (int e = 1; e <= len; e++) if (h_out[k][e] == 1 && h_out[k][e-1] == 0) n++;
        return n;
    endfunction

    task automatic zeros(input string tag);
        chk({tag, "_out_a"}, int'(out_a), 0);  chk({tag, "_busy_a"}, int'(busy_a), 0);
        chk({tag, "_pend_a"}, int'(pend_a), 0); chk({tag, "_ovf_a"}, int'(ovf_a), 0);
        chk({tag, "_out_b"}, int'(out_b), 0);  chk({tag, "_busy_b"}, int'(busy_b), 0);
        chk({tag, "_pend_b"}, int'(pend_b), 0); chk({tag, "_ovf_b"}, int'(ovf_b), 0);
    endtask

    task automatic single_checks(input string tag);
        for (int e = 2; e <= 5; e++) chk($sformatf("%s_out@%0d", tag, e), h_out[0][e], 1);
        chk({tag, "_out@1"}, h_out[0][1], 0);
        chk({tag, "_out@6"}, h_out[0][6], 0);
        chk({tag, "_busy@7"}, h_busy[0][7], 1);
        chk({tag, "_busy@8"}, h_busy[0][8], 0);
        chk({tag, "_pend@3"}, h_pend[0][3], 0);
        chk({tag, "_ovf@5"}, h_ovf[0][5], 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 zeros("rst");

        // single pulse
        restart();
        scen(64'd1 << 2, 14);
        single_checks("A");

        // three pulses back to back
        restart();
        scen((64'd1 << 2) | (64'd1 << 3) | (64'd1 << 4), 22);
        chk("B_out@7", h_out[0][7], 0);   chk("B_out@8", h_out[0][8], 1);
        chk("B_out@11", h_out[0][11], 1); chk("B_out@12", h_out[0][12], 0);
        chk("B_out@14", h_out[0][14], 1); chk("B_out@17", h_out[0][17], 1);
        chk("B_out@18", h_out[0][18], 0);
        chk("B_pend@3", h_pend[0][3], 1); chk("B_pend@4", h_pend[0][4], 2);
        chk("B_pend@8", h_pend[0][8], 1); chk("B_pend@14", h_pend[0][14], 0);
        chk("B_g0_out@13", h_out[1][13], 1); chk("B_g0_out@14", h_out[1][14], 0);

        // five pulses: saturation and drop
        restart();
        scen((64'd1 << 2) | (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 5) | (64'd1 << 6), 34);
        chk("C_pend@5", h_pend[0][5], 3);
        chk("C_pend@6", h_pend[0][6], 3);
        chk("C_ovf@5", h_ovf[0][5], 0);
        chk("C_ovf@6", h_ovf[0][6], int'(OVF_EN));
        chk("C_rises", rises(0, 34), 4);

        // pulse on the final gap edge with one event pending
        restart();
        scen((64'd1 << 2) | (64'd1 << 3) | (64'd1 << 8), 24);
        chk("D_pend@7", h_pend[0][7], 1);
        chk("D_pend@8", h_pend[0][8], 1);
        chk("D_pend@14", h_pend[0][14], 0);
        chk("D_out@14", h_out[0][14], 1); chk("D_out@17", h_out[0][17], 1);
        chk("D_out@18", h_out[0][18], 0);
        chk("D_busy@19", h_busy[0][19], 1); chk("D_busy@20", h_busy[0][20], 0);
        chk("D_rises", rises(0, 24), 3);

        // GAP=0 merge
        restart();
        scen((64'd1 << 2) | (64'd1 << 3), 14);
        for (int e = 2; e <= 9; e++) chk($sformatf("F_g0_out@%0d", e), h_out[1][e], 1);
        chk("F_g0_out@10", h_out[1][10], 0);
        chk("F_g0_busy@9", h_busy[1][9], 1);
        chk("F_g0_busy@10", h_busy[1][10], 0);
        chk("F_rises_g0", rises(1, 14), 1);

        // asynchronous reset in the middle of an ON period
        restart();
        scen(64'd1 << 2, 3);
        chk("E_out_pre", int'(out_a), 1);
        chk_en = 1'b0;
        #1 reset = 1'b1;
        #1 zeros("E_rst");
        restart();
        scen(64'd1 << 2, 14);
        single_checks("E");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
